id_ex_operand_stage: RTL and testbench
======================================

// Module: id_ex_operand_stage
// PURPOSE
//  ID/EX pipeline register directly downstream of the 64-bit register file.
//  - Captures ReadData1/2 plus decode controls.
//  - Patches same-edge writeback: regfile write-then-read is not write-through.
//  - Forwards EX/MEM and MEM/WB results into the EX-stage operands.
//  - Detects load-use hazards and injects a bubble.
// PARAMETERS
//  WIDTH     64  operand/result width
//  REGBITS   5   register index width
//  ZERO_REG  31  hard-wired zero register (XZR); never matched for bypass or hazard
// PORTS
//  clk              in   1        rising-edge clock
//  reset            in   1        asynchronous, active-low reset
//  id_valid         in   1        ID holds a real instruction
//  id_rs1, id_rs2   in   REGBITS  source indices (drive regfile ReadRegister1/2)
//  id_rd1, id_rd2   in   WIDTH    regfile ReadData1/2
//  id_rd            in   REGBITS  destination index
//  id_RegWrite      in   1        instruction writes id_rd
//  id_MemRead       in   1        instruction is a load
//  flush            in   1        squash the instruction entering EX (branch taken)
//  exmem_RegWrite   in   1        EX/MEM write enable
//  exmem_rd         in   REGBITS  EX/MEM destination index
//  exmem_result     in   WIDTH    EX/MEM ALU result
//  wb_RegWrite      in   1        MEM/WB write enable (same signal as regfile RegWrite)
//  wb_rd            in   REGBITS  MEM/WB destination (same as regfile WriteRegister)
//  wb_data          in   WIDTH    MEM/WB data (same as regfile WriteData)
//  stall            out  1        combinational: hold PC and IF/ID this cycle
//  ex_valid         out  1        EX holds a real instruction
//  ex_rd            out  REGBITS  registered destination
//  ex_RegWrite      out  1        registered; 0 when ex_valid=0
//  ex_MemRead       out  1        registered; 0 when ex_valid=0
//  ex_a, ex_b       out  WIDTH    forwarded EX operands (combinational from state)
// BEHAVIOUR
//  Reset (reset=0, async)
//  - ex_valid, ex_RegWrite, ex_MemRead, ex_rd, latched operands and source tags -> 0.
//  - ex_a and ex_b therefore read 0.
//  Hazard detection
//  - stall = id_valid & ex_valid & ex_MemRead & ex_rd!=ZERO_REG
//          & (ex_rd==id_rs1 | ex_rd==id_rs2).
//  Capture (each rising edge, reset=1)
//  - If flush | stall | !id_valid: load a bubble.
//    - Bubble: ex_valid=0, ex_RegWrite=0, ex_MemRead=0, ex_rd=ZERO_REG, operands 0.
//  - Otherwise:
//    - Load id_rd, id_RegWrite, id_MemRead, id_rs1, id_rs2 as source tags; ex_valid=1.
//    - Latched opN = wb_data if wb_RegWrite & wb_rd==id_rsN & id_rsN!=ZERO_REG,
//      else id_rdN.
//  - flush with stall: flush wins; bubble loaded, stall still asserted.
//  EX forwarding (combinational, per operand N)
//  - Priority 1: exmem_result if exmem_RegWrite & exmem_rd==srcN & srcN!=ZERO_REG.
//  - Priority 2: wb_data if wb_RegWrite & wb_rd==srcN & srcN!=ZERO_REG.
//  - Else the latched opN.
//  - While ex_valid=0, ex_a=ex_b=0 and no forwarding applies.
//  - Source ZERO_REG always yields the latched value, which is 0 from the regfile.
//  Latency and boundary cases
//  - One cycle from ID to EX.
//  - A stalled instruction stays presented upstream and is re-captured next cycle.
//    The bubble clears the hazard, so a stall lasts exactly one cycle per load-use.
//  - Reset deasserted mid-stream: the first capture edge after reset behaves normally.
// CONFIGURATION
//  HAZARD_STATS_EN defined:
//  - Adds outputs stall_count[15:0] and flush_count[15:0].
//  - Saturating counters, reset to 0 by reset.
//  - Each increments by 1 per cycle in which stall (resp. flush) is high.
//  - They hold at 16'hFFFF.
//  HAZARD_STATS_EN undefined:
//  - The ports and counters do not exist; all other behaviour is identical.
// TESTING
//  1. reset=0 mid-stream -> ex_valid=0, ex_a=ex_b=0 immediately, no clock edge needed.
//  2. EX/MEM forward:
//     - EX/MEM has rd=X3, RegWrite=1, result=64'h55; EX has src1=X3, latched 64'h11.
//     - Expect ex_a=64'h55.
//     - With MEM/WB also rd=X3 data=64'h66, ex_a stays 64'h55 (priority).
//  3. Same-edge writeback:
//     - wb rd=X7, data=64'hAB, RegWrite=1; ID rs2=X7, id_rd2=64'h0 (stale).
//     - Expect ex_b=64'hAB next cycle with no EX/MEM match.
//  4. Load-use:
//     - EX holds a load to X2; ID reads rs1=X2.
//     - Expect stall=1 for exactly one cycle and a bubble in EX.
//     - Next cycle the instruction is captured with stall=0.
//  5. Zero register:
//     - EX/MEM rd=X31, RegWrite=1, result=64'hFF; EX src1=X31 -> ex_a=0.
//     - A load to X31 with ID rs1=X31 -> stall=0.
//  6. flush=1 together with stall=1 -> bubble loaded (ex_valid=0).
//     - With HAZARD_STATS_EN: stall_count and flush_count each +1.

Source files
------------

// File: rtl/id_ex_operand_stage.sv
// -----------------------------------------------------------------------------
// id_ex_operand_stage
//
// Purpose:
//   ID/EX pipeline register that sits directly behind a 64-bit register file.
//   It captures the register-file read data and the decode controls, and it
//   patches a writeback happening on the same edge, because the regfile does
//   not write through. It forwards EX/MEM and MEM/WB results into the EX
//   operands, and it detects load-use hazards and inserts a bubble.
//
// Flow control:
//   This is a valid-only pipeline with no ready signal. id_valid marks a real
//   instruction in ID. stall is the single back-pressure signal: while it is
//   high, upstream must hold PC and IF/ID so that the same instruction is
//   presented again next cycle. ex_valid marks a real instruction in EX.
//
// Optional feature (macro HAZARD_STATS_EN):
//   Defining this macro adds two saturating 16-bit counters, stall_count and
//   flush_count. When the macro is undefined, these ports do not exist.
//
// Ports:
//   clk, reset                  rising-edge clock, async active-low reset
//   id_valid                    ID holds a real instruction
//   id_rs1, id_rs2              source register indices
//   id_rd1, id_rd2              regfile ReadData1/2
//   id_rd                       destination index
//   id_RegWrite, id_MemRead     decode controls
//   flush                       squash the instruction entering EX
//   exmem_RegWrite/rd/result    EX/MEM bypass source
//   wb_RegWrite/rd/data         MEM/WB bypass source (also the regfile write port)
//   stall                       combinational load-use stall
//   ex_valid, ex_rd             registered EX state
//   ex_RegWrite, ex_MemRead     registered controls, 0 in a bubble
//   ex_a, ex_b                  forwarded EX operands
//   stall_count, flush_count    (HAZARD_STATS_EN only) saturating event counters
// -----------------------------------------------------------------------------
module id_ex_operand_stage #(
  parameter int WIDTH    = 64,
  parameter int REGBITS  = 5,
  parameter int ZERO_REG = 31
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               id_valid,
  input  logic [REGBITS-1:0] id_rs1,
  input  logic [REGBITS-1:0] id_rs2,
  input  logic [WIDTH-1:0]   id_rd1,
  input  logic [WIDTH-1:0]   id_rd2,
  input  logic [REGBITS-1:0] id_rd,
  input  logic               id_RegWrite,
  input  logic               id_MemRead,
  input  logic               flush,
  input  logic               exmem_RegWrite,
  input  logic [REGBITS-1:0] exmem_rd,
  input  logic [WIDTH-1:0]   exmem_result,
  input  logic               wb_RegWrite,
  input  logic [REGBITS-1:0] wb_rd,
  input  logic [WIDTH-1:0]   wb_data,
  output logic               stall,
  output logic               ex_valid,
  output logic [REGBITS-1:0] ex_rd,
  output logic               ex_RegWrite,
  output logic               ex_MemRead,
  output logic [WIDTH-1:0]   ex_a,
  output logic [WIDTH-1:0]   ex_b
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0]        stall_count,
  output logic [15:0]        flush_count
`endif
);

  localparam logic [REGBITS-1:0] LP_ZERO = REGBITS'(ZERO_REG);

  // EX-stage state
  logic               r_ex_valid;
  logic [REGBITS-1:0] r_ex_rd;
  logic               r_ex_regwrite;
  logic               r_ex_memread;
  logic [REGBITS-1:0] r_src1;
  logic [REGBITS-1:0] r_src2;
  logic [WIDTH-1:0]   r_op1;
  logic [WIDTH-1:0]   r_op2;

  logic               w_stall;
  logic               w_capture;
  logic               w_wb_hit1;
  logic               w_wb_hit2;
  logic [WIDTH-1:0]   w_cap_op1;
  logic [WIDTH-1:0]   w_cap_op2;
  logic [WIDTH-1:0]   w_ex_a;
  logic [WIDTH-1:0]   w_ex_b;

  // Load-use: the load in EX has not produced its data yet, so a consumer in
  // ID must wait one cycle. Writes to the zero register never create a hazard.
  assign w_stall = id_valid & r_ex_valid & r_ex_memread & (r_ex_rd != LP_ZERO)
                 & ((r_ex_rd == id_rs1) | (r_ex_rd == id_rs2));

  assign w_capture = id_valid & ~flush & ~w_stall;

  // The regfile reads the old value on the same edge that it writes, so a
  // writeback to one of our sources must be patched in at capture time.
  assign w_wb_hit1 = wb_RegWrite & (wb_rd == id_rs1) & (id_rs1 != LP_ZERO);
  assign w_wb_hit2 = wb_RegWrite & (wb_rd == id_rs2) & (id_rs2 != LP_ZERO);
  assign w_cap_op1 = w_wb_hit1 ? wb_data : id_rd1;
  assign w_cap_op2 = w_wb_hit2 ? wb_data : id_rd2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ex_valid    <= 1'b0;
      r_ex_rd       <= '0;
      r_ex_regwrite <= 1'b0;
      r_ex_memread  <= 1'b0;
      r_src1        <= '0;
      r_src2        <= '0;
      r_op1         <= '0;
      r_op2         <= '0;
    end else if (!w_capture) begin
      // Bubble. Flush takes priority over stall, and both produce this.
      r_ex_valid    <= 1'b0;
      r_ex_rd       <= LP_ZERO;
      r_ex_regwrite <= 1'b0;
      r_ex_memread  <= 1'b0;
      r_src1        <= '0;
      r_src2        <= '0;
      r_op1         <= '0;
      r_op2         <= '0;
    end else begin
      r_ex_valid    <= 1'b1;
      r_ex_rd       <= id_rd;
      r_ex_regwrite <= id_RegWrite;
      r_ex_memread  <= id_MemRead;
      r_src1        <= id_rs1;
      r_src2        <= id_rs2;
      r_op1         <= w_cap_op1;
      r_op2         <= w_cap_op2;
    end
  end

  // EX forwarding: the younger EX/MEM result beats MEM/WB. A bubble presents
  // zeros regardless of what is being written back.
  always_comb begin
    w_ex_a = '0;
    w_ex_b = '0;
    if (r_ex_valid) begin
      if (exmem_RegWrite && (exmem_rd == r_src1) && (r_src1 != LP_ZERO))
        w_ex_a = exmem_result;
      else if (wb_RegWrite && (wb_rd == r_src1) && (r_src1 != LP_ZERO))
        w_ex_a = wb_data;
      else
        w_ex_a = r_op1;

      if (exmem_RegWrite && (exmem_rd == r_src2) && (r_src2 != LP_ZERO))
        w_ex_b = exmem_result;
      else if (wb_RegWrite && (wb_rd == r_src2) && (r_src2 != LP_ZERO))
        w_ex_b = wb_data;
      else
        w_ex_b = r_op2;
    end
  end

  assign stall       = w_stall;
  assign ex_valid    = r_ex_valid;
  assign ex_rd       = r_ex_rd;
  assign ex_RegWrite = r_ex_regwrite;
  assign ex_MemRead  = r_ex_memread;
  assign ex_a        = w_ex_a;
  assign ex_b        = w_ex_b;

`ifdef HAZARD_STATS_EN
  logic [15:0] r_stall_count;
  logic [15:0] r_flush_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (w_stall && (r_stall_count != 16'hFFFF))
        r_stall_count <= r_stall_count + 16'd1;
      if (flush && (r_flush_count != 16'hFFFF))
        r_flush_count <= r_flush_count + 16'd1;
    end
  end

  assign stall_count = r_stall_count;
  assign flush_count = r_flush_count;
`endif

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_operand_stage
//
// Directed bench for id_ex_operand_stage. Inputs change on the falling edge,
// registered outputs are sampled on the falling edge after a capture, and
// combinational outputs are sampled 1 ns after the inputs change.
// -----------------------------------------------------------------------------
module tb_id_ex_operand_stage;

  localparam int WIDTH   = 64;
  localparam int REGBITS = 5;

  // clock / reset
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic               id_valid;
  logic [REGBITS-1:0] id_rs1, id_rs2, id_rd;
  logic [WIDTH-1:0]   id_rd1, id_rd2;
  logic               id_RegWrite, id_MemRead, flush;
  logic               exmem_RegWrite;
  logic [REGBITS-1:0] exmem_rd;
  logic [WIDTH-1:0]   exmem_result;
  logic               wb_RegWrite;
  logic [REGBITS-1:0] wb_rd;
  logic [WIDTH-1:0]   wb_data;
  logic               stall, ex_valid, ex_RegWrite, ex_MemRead;
  logic [REGBITS-1:0] ex_rd;
  logic [WIDTH-1:0]   ex_a, ex_b;
`ifdef HAZARD_STATS_EN
  logic [15:0]        stall_count, flush_count;
`endif

  id_ex_operand_stage dut (
    .clk            (clk),
    .reset          (reset),
    .id_valid       (id_valid),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_rd1         (id_rd1),
    .id_rd2         (id_rd2),
    .id_rd          (id_rd),
    .id_RegWrite    (id_RegWrite),
    .id_MemRead     (id_MemRead),
    .flush          (flush),
    .exmem_RegWrite (exmem_RegWrite),
    .exmem_rd       (exmem_rd),
    .exmem_result   (exmem_result),
    .wb_RegWrite    (wb_RegWrite),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .stall          (stall),
    .ex_valid       (ex_valid),
    .ex_rd          (ex_rd),
    .ex_RegWrite    (ex_RegWrite),
    .ex_MemRead     (ex_MemRead),
    .ex_a           (ex_a),
    .ex_b           (ex_b)
`ifdef HAZARD_STATS_EN
    ,
    .stall_count    (stall_count),
    .flush_count    (flush_count)
`endif
  );

  // scoreboard counters
  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [WIDTH-1:0] got,
                          input logic [WIDTH-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic drive_id(input logic v, input logic [REGBITS-1:0] rs1,
                          input logic [REGBITS-1:0] rs2, input logic [WIDTH-1:0] d1,
                          input logic [WIDTH-1:0] d2, input logic [REGBITS-1:0] rd,
                          input logic rw, input logic mr);
    id_valid    = v;
    id_rs1      = rs1;
    id_rs2      = rs2;
    id_rd1      = d1;
    id_rd2      = d2;
    id_rd       = rd;
    id_RegWrite = rw;
    id_MemRead  = mr;
  endtask

  task automatic drive_exmem(input logic rw, input logic [REGBITS-1:0] rd,
                             input logic [WIDTH-1:0] res);
    exmem_RegWrite = rw;
    exmem_rd       = rd;
    exmem_result   = res;
  endtask

  task automatic drive_wb(input logic rw, input logic [REGBITS-1:0] rd,
                          input logic [WIDTH-1:0] d);
    wb_RegWrite = rw;
    wb_rd       = rd;
    wb_data     = d;
  endtask

  // one capture edge, return on the following falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    drive_id(1'b0, 5'd0, 5'd0, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0);
    drive_exmem(1'b0, 5'd0, 64'h0);
    drive_wb(1'b0, 5'd0, 64'h0);
    flush = 1'b0;

    // reset state
    #1;
    check_eq("rst_valid", 64'(ex_valid), 64'd0);
    check_eq("rst_a", ex_a, 64'h0);
    check_eq("rst_b", ex_b, 64'h0);
    check_eq("rst_rd", 64'(ex_rd), 64'd0);
    check_eq("rst_stall", 64'(stall), 64'd0);
`ifdef HAZARD_STATS_EN
    check_eq("rst_scnt", 64'(stall_count), 64'd0);
    check_eq("rst_fcnt", 64'(flush_count), 64'd0);
`endif
    @(negedge clk);
    reset = 1'b1;

    // plain capture, then EX/MEM and MEM/WB forwarding priority
    drive_id(1'b1, 5'd3, 5'd4, 64'h11, 64'h22, 5'd5, 1'b1, 1'b0);
    step();
    check_eq("cap_valid", 64'(ex_valid), 64'd1);
    check_eq("cap_rd", 64'(ex_rd), 64'd5);
    check_eq("cap_rw", 64'(ex_RegWrite), 64'd1);
    check_eq("cap_mr", 64'(ex_MemRead), 64'd0);
    check_eq("cap_a", ex_a, 64'h11);
    check_eq("cap_b", ex_b, 64'h22);
    drive_id(1'b0, 5'd0, 5'd0, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0);
    drive_exmem(1'b1, 5'd3, 64'h55);
    #1;
    check_eq("exmem_fwd_a", ex_a, 64'h55);
    check_eq("exmem_fwd_b_untouched", ex_b, 64'h22);
    drive_wb(1'b1, 5'd3, 64'h66);
    #1;
    check_eq("exmem_beats_wb", ex_a, 64'h55);
    drive_exmem(1'b0, 5'd3, 64'h55);
    #1;
    check_eq("wb_fwd_a", ex_a, 64'h66);
    drive_exmem(1'b1, 5'd4, 64'h44);
    #1;
    check_eq("exmem_fwd_b", ex_b, 64'h44);

    // same-edge writeback patch
    @(negedge clk);
    drive_exmem(1'b0, 5'd0, 64'h0);
    drive_wb(1'b1, 5'd7, 64'hAB);
    drive_id(1'b1, 5'd1, 5'd7, 64'h10, 64'h0, 5'd8, 1'b1, 1'b0);
    step();
    drive_wb(1'b0, 5'd0, 64'h0);
    #1;
    check_eq("wb_patch_b", ex_b, 64'hAB);
    check_eq("wb_patch_a", ex_a, 64'h10);

    // load-use: load X2, then consumer of X2
    @(negedge clk);
    drive_id(1'b1, 5'd1, 5'd5, 64'h1, 64'h2, 5'd2, 1'b1, 1'b1);
    step();
    check_eq("load_mr", 64'(ex_MemRead), 64'd1);
    check_eq("load_rd", 64'(ex_rd), 64'd2);
    drive_id(1'b1, 5'd2, 5'd9, 64'h20, 64'h30, 5'd10, 1'b1, 1'b0);
    #1;
    check_eq("lu_stall", 64'(stall), 64'd1);
    step();
    check_eq("lu_bubble_valid", 64'(ex_valid), 64'd0);
    check_eq("lu_bubble_rd", 64'(ex_rd), 64'd31);
    check_eq("lu_bubble_rw", 64'(ex_RegWrite), 64'd0);
    check_eq("lu_bubble_mr", 64'(ex_MemRead), 64'd0);
    check_eq("lu_stall_gone", 64'(stall), 64'd0);
    drive_exmem(1'b1, 5'd0, 64'h77);
    drive_wb(1'b1, 5'd0, 64'h78);
    #1;
    check_eq("bubble_no_fwd_a", ex_a, 64'h0);
    check_eq("bubble_no_fwd_b", ex_b, 64'h0);
    drive_exmem(1'b0, 5'd0, 64'h0);
    drive_wb(1'b0, 5'd0, 64'h0);
    step();
    check_eq("lu_recap_valid", 64'(ex_valid), 64'd1);
    check_eq("lu_recap_rd", 64'(ex_rd), 64'd10);
    check_eq("lu_recap_a", ex_a, 64'h20);
    check_eq("lu_recap_b", ex_b, 64'h30);
    check_eq("lu_recap_stall", 64'(stall), 64'd0);

    // zero register: load to X31 reading X31, writeback to X31 on same edge
    drive_id(1'b1, 5'd31, 5'd31, 64'h0, 64'h0, 5'd31, 1'b1, 1'b1);
    drive_wb(1'b1, 5'd31, 64'hEE);
    step();
    drive_exmem(1'b1, 5'd31, 64'hFF);
    #1;
    check_eq("zr_exmem_a", ex_a, 64'h0);
    check_eq("zr_wb_b", ex_b, 64'h0);
    check_eq("zr_load_mr", 64'(ex_MemRead), 64'd1);
    check_eq("zr_no_stall", 64'(stall), 64'd0);
    drive_exmem(1'b0, 5'd0, 64'h0);
    drive_wb(1'b0, 5'd0, 64'h0);

    // invalid ID loads a bubble
    @(negedge clk);
    drive_id(1'b0, 5'd3, 5'd4, 64'h5, 64'h6, 5'd3, 1'b1, 1'b0);
    step();
    check_eq("novalid_bubble", 64'(ex_valid), 64'd0);
    check_eq("novalid_rw", 64'(ex_RegWrite), 64'd0);

    // flush together with stall
    drive_id(1'b1, 5'd1, 5'd1, 64'h1, 64'h1, 5'd2, 1'b1, 1'b1);
    step();
    drive_id(1'b1, 5'd2, 5'd3, 64'h9, 64'h8, 5'd4, 1'b1, 1'b0);
    flush = 1'b1;
    #1;
    check_eq("fs_stall", 64'(stall), 64'd1);
    step();
    check_eq("fs_bubble", 64'(ex_valid), 64'd0);
    check_eq("fs_bubble_a", ex_a, 64'h0);
`ifdef HAZARD_STATS_EN
    check_eq("fs_scnt", 64'(stall_count), 64'd2);
    check_eq("fs_fcnt", 64'(flush_count), 64'd1);
`endif
    // flush alone squashes a hazard-free instruction
    #1;
    check_eq("flush_only_no_stall", 64'(stall), 64'd0);
    step();
    check_eq("flush_only_bubble", 64'(ex_valid), 64'd0);
    flush = 1'b0;
    step();
    check_eq("post_flush_valid", 64'(ex_valid), 64'd1);
    check_eq("post_flush_a", ex_a, 64'h9);

    // reset mid-stream, asynchronous
    #2;
    reset = 1'b0;
    #1;
    check_eq("async_rst_valid", 64'(ex_valid), 64'd0);
    check_eq("async_rst_a", ex_a, 64'h0);
    check_eq("async_rst_b", ex_b, 64'h0);
    check_eq("async_rst_rd", 64'(ex_rd), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    drive_id(1'b1, 5'd6, 5'd7, 64'hC0, 64'hD0, 5'd12, 1'b0, 1'b0);
    step();
    check_eq("post_rst_valid", 64'(ex_valid), 64'd1);
    check_eq("post_rst_a", ex_a, 64'hC0);
    check_eq("post_rst_rd", 64'(ex_rd), 64'd12);
    check_eq("post_rst_rw", 64'(ex_RegWrite), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
